// File: rtl/dm_port_arbiter_pkg.sv
// Shared types for the data-memory port arbiter.
// Arbiter FSM states, read-return owners and the idle write-enable value.
package dm_arb_pkg;

    typedef enum logic {
        ARB,
        DMA_LOCK
    } arb_state_e;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_CPU,
        OWN_DMA
    } owner_e;

    localparam logic [3:0] WEB_NONE = 4'b1111;

endpackage

// File: rtl/dm_port_arbiter_if.sv
// Bundle of CPU, DMA and SRAM signals around the data-memory arbiter.
// slave is the arbiter's view, master is the surrounding system's view.
interface dm_port_arbiter_if #(
    parameter int ADDR_W = 14
) ();

    logic              cpu_req;
    logic [3:0]        cpu_web;
    logic [ADDR_W-1:0] cpu_addr;
    logic [31:0]       cpu_wdata;
    logic              cpu_gnt;
    logic              cpu_stall;
    logic              cpu_rvalid;
    logic [31:0]       cpu_rdata;

    logic              dma_req;
    logic [3:0]        dma_web;
    logic [ADDR_W-1:0] dma_addr;
    logic [31:0]       dma_wdata;
    logic              dma_last;
    logic              dma_gnt;
    logic              dma_rvalid;
    logic [31:0]       dma_rdata;

    logic              dm_cs;
    logic              dm_oe;
    logic [3:0]        dm_web;
    logic [ADDR_W-1:0] dm_a;
    logic [31:0]       dm_di;
    logic [31:0]       dm_do;

    modport slave (
        input  cpu_req, cpu_web, cpu_addr, cpu_wdata,
        output cpu_gnt, cpu_stall, cpu_rvalid, cpu_rdata,
        input  dma_req, dma_web, dma_addr, dma_wdata, dma_last,
        output dma_gnt, dma_rvalid, dma_rdata,
        output dm_cs, dm_oe, dm_web, dm_a, dm_di,
        input  dm_do
    );

    modport master (
        output cpu_req, cpu_web, cpu_addr, cpu_wdata,
        input  cpu_gnt, cpu_stall, cpu_rvalid, cpu_rdata,
        output dma_req, dma_web, dma_addr, dma_wdata, dma_last,
        input  dma_gnt, dma_rvalid, dma_rdata,
        input  dm_cs, dm_oe, dm_web, dm_a, dm_di,
        output dm_do
    );

endinterface

// File: rtl/dm_port_arbiter_starve.sv
// Saturating wait counter for the DMA starvation guard.
// Counts cycles the DMA waits, clears when it is served.
module dm_starve_counter #(
    parameter int LIMIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic sat
);

    localparam int W = $clog2(LIMIT + 1);

    logic [W-1:0] cnt;

    assign sat = (cnt == W'(LIMIT));

    // Count waiting cycles, hold at the limit, clear on service.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && !sat) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/dm_port_arbiter.sv
// Data SRAM arbiter between the CPU M-stage port and the DMA port.
// CPU first, DMA starvation guard, DMA burst lock, 1-cycle read return.
module dm_port_arbiter
    import dm_arb_pkg::*;
#(
    parameter int ADDR_W       = 14,
    parameter int STARVE_LIMIT = 4,
    parameter int MAX_BURST    = 8
) (
    input  logic            clk,
    input  logic            rst,
    dm_port_arbiter_if.slave bus
);

    localparam int BW = $clog2(MAX_BURST + 1);

    arb_state_e    state;
    logic [BW-1:0] beat_cnt;
    owner_e        rd_owner;

    logic starved;
    logic cpu_win;
    logic dma_win;
    logic cpu_rd;
    logic dma_rd;
    logic cpu_rv;
    logic dma_rv;

    dm_starve_counter #(
        .LIMIT (STARVE_LIMIT)
    ) u_starve (
        .clk (clk),
        .rst (rst),
        .inc (bus.dma_req & ~dma_win),
        .clr (dma_win),
        .sat (starved)
    );

    // Pick at most one winner this cycle; nothing wins while in reset.
    always_comb begin
        cpu_win = 1'b0;
        dma_win = 1'b0;
        if (rst) begin
            if (state == DMA_LOCK) begin
                dma_win = bus.dma_req;
            end else if (bus.dma_req && starved) begin
                dma_win = 1'b1;
            end else if (bus.cpu_req) begin
                cpu_win = 1'b1;
            end else begin
                dma_win = bus.dma_req;
            end
        end
    end

    assign cpu_rd = cpu_win && (bus.cpu_web == WEB_NONE);
    assign dma_rd = dma_win && (bus.dma_web == WEB_NONE);

    assign bus.cpu_gnt   = cpu_win;
    assign bus.dma_gnt   = dma_win;
    assign bus.cpu_stall = rst & bus.cpu_req & ~cpu_win;

    // Steer the winner onto the SRAM pins; idle pins when no grant.
    always_comb begin
        bus.dm_cs  = cpu_win | dma_win;
        bus.dm_oe  = cpu_rd | dma_rd;
        bus.dm_web = WEB_NONE;
        bus.dm_a   = {ADDR_W{1'b0}};
        bus.dm_di  = 32'h0;
        if (cpu_win) begin
            bus.dm_web = bus.cpu_web;
            bus.dm_a   = bus.cpu_addr;
            bus.dm_di  = bus.cpu_wdata;
        end else if (dma_win) begin
            bus.dm_web = bus.dma_web;
            bus.dm_a   = bus.dma_addr;
            bus.dm_di  = bus.dma_wdata;
        end
    end

    assign cpu_rv         = rst && (rd_owner == OWN_CPU);
    assign dma_rv         = rst && (rd_owner == OWN_DMA);
    assign bus.cpu_rvalid = cpu_rv;
    assign bus.dma_rvalid = dma_rv;
    assign bus.cpu_rdata  = cpu_rv ? bus.dm_do : 32'h0;
    assign bus.dma_rdata  = dma_rv ? bus.dm_do : 32'h0;

    // Burst-lock FSM, beat counting and read-return owner tracking.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= ARB;
            beat_cnt <= '0;
            rd_owner <= OWN_NONE;
        end else begin
            rd_owner <= cpu_rd ? OWN_CPU :
                        dma_rd ? OWN_DMA : OWN_NONE;
            unique case (state)
                ARB: begin
                    if (dma_win && !bus.dma_last) begin
                        state    <= DMA_LOCK;
                        beat_cnt <= BW'(1);
                    end
                end
                DMA_LOCK: begin
                    if (!bus.dma_req) begin
                        state    <= ARB;
                        beat_cnt <= '0;
                    end else if (bus.dma_last ||
                                 beat_cnt == BW'(MAX_BURST - 1)) begin
                        state    <= ARB;
                        beat_cnt <= '0;
                    end else begin
                        beat_cnt <= beat_cnt + 1'b1;
                    end
                end
                default: begin
                    state    <= ARB;
                    beat_cnt <= '0;
                end
            endcase
        end
    end

endmodule
